// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings, bridge state type and the byte-strobe helper
// used by the AHB-Lite to APB4 bridge.
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDATA,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } bridge_state_e;

   // Byte lanes touched by a transfer of 2^hsize bytes at the given lane offset.
   function automatic logic [7:0] size_to_strb(input logic [2:0] hsize,
                                               input logic [2:0] addr_lsbs,
                                               input int         data_w);
      logic [7:0] ones;
      logic [2:0] lane;
      case (hsize)
         3'd0:    ones = 8'h01;
         3'd1:    ones = 8'h03;
         3'd2:    ones = 8'h0F;
         default: ones = 8'hFF;
      endcase
      lane = (data_w == 64) ? addr_lsbs : {1'b0, addr_lsbs[1:0]};
      return ones << lane;
   endfunction

endpackage

// File: rtl/ahb_apb_decoder.sv
// Combinational window decode: one-hot slave select plus decode and
// alignment fault flags for the current AHB address phase.
module ahb_apb_decoder #(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter int                NUM_SLAVES   = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] REGION_BYTES = 32'h1000
)(
   input  logic [ADDR_W-1:0]     i_haddr,
   input  logic [2:0]            i_hsize,
   output logic [NUM_SLAVES-1:0] o_sel,
   output logic                  o_decode_err,
   output logic                  o_align_err
);

   localparam int         REGION_SHIFT = $clog2(REGION_BYTES);
   localparam logic [2:0] MAX_SIZE     = 3'($clog2(DATA_W / 8));

   logic [ADDR_W-1:0] w_offset;
   logic [ADDR_W-1:0] w_region;
   logic              w_in_range;
   logic [2:0]        w_size_mask;

   // Range test on the region number rather than the byte limit, so a window
   // that ends at the top of the address space cannot overflow.
   assign w_offset   = i_haddr - BASE_ADDR;
   assign w_region   = w_offset >> REGION_SHIFT;
   assign w_in_range = (i_haddr >= BASE_ADDR) && (w_region < ADDR_W'(NUM_SLAVES));

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      o_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         o_sel[i] = w_in_range && (w_region == ADDR_W'(i));
      end
   end

   always_comb begin
      case (i_hsize)
         3'd0:    w_size_mask = 3'b000;
         3'd1:    w_size_mask = 3'b001;
         3'd2:    w_size_mask = 3'b011;
         default: w_size_mask = 3'b111;
      endcase
   end

   assign o_decode_err = !w_in_range;
   assign o_align_err  = (i_hsize > MAX_SIZE) || (|(i_haddr[2:0] & w_size_mask));

endmodule

// File: rtl/ahb2apb_bridge_mslv.sv
// AHB-Lite slave to APB4 master bridge for NUM_SLAVES peripherals in one
// contiguous window, with two-cycle ERROR responses and an ACCESS timeout.
module ahb2apb_bridge_mslv
   import ahb_apb_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter int                NUM_SLAVES   = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] REGION_BYTES = 32'h1000,
   parameter int                TIMEOUT      = 16
)(
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic [ADDR_W-1:0]     haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [DATA_W-1:0]     hwdata,
   input  logic                  hreadyin,
   output logic                  hreadyout,
   output logic [1:0]            hresp,
   output logic [DATA_W-1:0]     hrdata,
   output logic [ADDR_W-1:0]     paddr,
   output logic [DATA_W-1:0]     pwdata,
   output logic                  pwrite,
   output logic [DATA_W/8-1:0]   pstrb,
   output logic [NUM_SLAVES-1:0] psel,
   output logic                  penable,
   input  logic [DATA_W-1:0]     prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   localparam int               STRB_W   = DATA_W / 8;
   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   bridge_state_e     r_state;
   logic              r_hreadyout;
   logic [1:0]        r_hresp;
   logic [DATA_W-1:0] r_hrdata;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic              r_pwrite;
   logic [STRB_W-1:0] r_pstrb;
   logic [NUM_SLAVES-1:0] r_psel;
   logic [NUM_SLAVES-1:0] r_sel;
   logic              r_penable;
   logic [CNT_W-1:0]  r_cnt;

   logic [NUM_SLAVES-1:0] w_sel;
   logic              w_decode_err;
   logic              w_align_err;
   logic              w_valid;
   logic [7:0]        w_strb_full;
   logic [STRB_W-1:0] w_strb;
   logic              w_unused;

   ahb_apb_decoder #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .NUM_SLAVES   (NUM_SLAVES),
      .BASE_ADDR    (BASE_ADDR),
      .REGION_BYTES (REGION_BYTES)
   ) u_decoder (
      .i_haddr      (haddr),
      .i_hsize      (hsize),
      .o_sel        (w_sel),
      .o_decode_err (w_decode_err),
      .o_align_err  (w_align_err)
   );

   assign w_valid     = hreadyin && htrans[1];
   assign w_strb_full = size_to_strb(hsize, haddr[2:0], DATA_W);
   assign w_strb      = w_strb_full[STRB_W-1:0];
   assign w_unused    = ^{htrans[0], w_strb_full};

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state     <= ST_IDLE;
         r_hreadyout <= 1'b1;
         r_hresp     <= HRESP_OKAY;
         r_hrdata    <= '0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_pwrite    <= 1'b0;
         r_pstrb     <= '0;
         r_psel      <= '0;
         r_sel       <= '0;
         r_penable   <= 1'b0;
         r_cnt       <= '0;
      end else begin
         // NOTE: non-blocking assignments only, so every registered output updates from the same pre-edge state.
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
               if (w_valid) begin
                  r_hreadyout <= 1'b0;
                  if (w_decode_err || w_align_err) begin
                     r_hresp <= HRESP_ERROR;
                     r_state <= ST_ERR1;
                  end else begin
                     r_hresp  <= HRESP_OKAY;
                     r_paddr  <= haddr;
                     r_pwrite <= hwrite;
                     r_pstrb  <= hwrite ? w_strb : '0;
                     r_sel    <= w_sel;
                     if (hwrite) begin
                        r_state <= ST_WDATA;
                     end else begin
                        r_psel  <= w_sel;
                        r_state <= ST_SETUP;
                     end
                  end
               end else begin
                  r_hreadyout <= 1'b1;
                  r_hresp     <= HRESP_OKAY;
                  r_state     <= ST_IDLE;
               end
            end
            ST_WDATA: begin
               r_pwdata <= hwdata;
               r_psel   <= r_sel;
               r_state  <= ST_SETUP;
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_cnt     <= '0;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (pready) begin
                  r_psel    <= '0;
                  r_penable <= 1'b0;
                  r_cnt     <= '0;
                  if (pslverr) begin
                     r_hresp <= HRESP_ERROR;
                     r_state <= ST_ERR1;
                  end else begin
                     r_hreadyout <= 1'b1;
                     if (!r_pwrite) r_hrdata <= prdata;
                     r_state <= ST_DONE;
                  end
               end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
                  // Slave never answered: abandon the access and report an error.
                  r_psel    <= '0;
                  r_penable <= 1'b0;
                  r_cnt     <= '0;
                  r_hresp   <= HRESP_ERROR;
                  r_state   <= ST_ERR1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_ERR1: begin
               r_hreadyout <= 1'b1;
               r_state     <= ST_ERR2;
            end
            default: begin
               r_hreadyout <= 1'b1;
               r_hresp     <= HRESP_OKAY;
               r_psel      <= '0;
               r_penable   <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign hreadyout = r_hreadyout;
   assign hresp     = r_hresp;
   assign hrdata    = r_hrdata;
   assign paddr     = r_paddr;
   assign pwdata    = r_pwdata;
   assign pwrite    = r_pwrite;
   assign pstrb     = r_pstrb;
   assign psel      = r_psel;
   assign penable   = r_penable;

endmodule

// File: tb/tb_ahb2apb_bridge_mslv.sv
// Directed bench for ahb2apb_bridge_mslv: a vector table of single transfers
// plus hand-written back-to-back and mid-access reset sequences.
module tb_ahb2apb_bridge_mslv;

   logic        hclk;
   logic        hresetn;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hreadyin;
   logic        hreadyout;
   logic [1:0]  hresp;
   logic [31:0] hrdata;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        pwrite;
   logic [3:0]  pstrb;
   logic [3:0]  psel;
   logic        penable;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   ahb2apb_bridge_mslv #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .NUM_SLAVES   (4),
      .BASE_ADDR    (32'h8000_0000),
      .REGION_BYTES (32'h1000),
      .TIMEOUT      (16)
   ) dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hwdata    (hwdata),
      .hreadyin  (hreadyin),
      .hreadyout (hreadyout),
      .hresp     (hresp),
      .hrdata    (hrdata),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pwrite    (pwrite),
      .pstrb     (pstrb),
      .psel      (psel),
      .penable   (penable),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      logic        slverr;
      logic [1:0]  resp;
      logic [3:0]  psel;
      logic [3:0]  pstrb;
      int          lat;
      int          acc;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   int          o_lat;
   int          o_acc;
   logic [1:0]  o_resp;
   logic [1:0]  o_prev_resp;
   logic [3:0]  o_psel;
   logic [3:0]  o_pstrb;
   logic [31:0] o_pwdata;
   logic [31:0] o_paddr;
   logic [31:0] o_hrdata;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, " hreadyout"}, 64'(hreadyout), 64'd1);
      check({tag, " hresp"},     64'(hresp),     64'd0);
      check({tag, " hrdata"},    64'(hrdata),    64'd0);
      check({tag, " paddr"},     64'(paddr),     64'd0);
      check({tag, " pwdata"},    64'(pwdata),    64'd0);
      check({tag, " pwrite"},    64'(pwrite),    64'd0);
      check({tag, " pstrb"},     64'(pstrb),     64'd0);
      check({tag, " psel"},      64'(psel),      64'd0);
      check({tag, " penable"},   64'(penable),   64'd0);
   endtask

   // One transfer: address phase, data phase, then a small APB slave model
   // that holds pready low for v.waits ACCESS cycles.
   task automatic run_vec(input vec_t v);
      @(posedge hclk); #1;
      haddr    = v.addr;
      htrans   = 2'b10;
      hwrite   = v.wr;
      hsize    = v.size;
      hreadyin = 1'b1;
      pready   = 1'b0;
      pslverr  = 1'b0;
      prdata   = v.rdata;
      @(posedge hclk); #1;
      htrans      = 2'b00;
      hwdata      = v.wdata;
      o_lat       = 0;
      o_acc       = 0;
      o_resp      = 2'b11;
      o_prev_resp = 2'b11;
      o_psel      = '0;
      o_pstrb     = '0;
      o_pwdata    = '0;
      o_paddr     = '0;
      o_hrdata    = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge hclk);
         if (psel != 4'b0000 && o_psel == 4'b0000) begin
            o_psel   = psel;
            o_pstrb  = pstrb;
            o_pwdata = pwdata;
            o_paddr  = paddr;
         end
         if (hreadyout) begin
            o_lat    = c;
            o_resp   = hresp;
            o_hrdata = hrdata;
            break;
         end
         o_prev_resp = hresp;
         if (psel != 4'b0000 && penable) begin
            pready  = (o_acc >= v.waits);
            pslverr = pready & v.slverr;
            o_acc++;
         end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
         end
      end
   endtask

   vec_t vecs [12];
   int   n_wait;

   initial begin
      vecs[0]  = '{32'h8000_1004, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0,         0,   1'b0, 2'b00, 4'b0010, 4'hF, 4,  1};
      vecs[1]  = '{32'h8000_3000, 1'b0, 3'd2, 32'h0,         32'h1234_5678, 3,   1'b0, 2'b00, 4'b1000, 4'h0, 6,  4};
      vecs[2]  = '{32'h8000_0003, 1'b1, 3'd0, 32'hAA00_0000, 32'h0,         0,   1'b0, 2'b00, 4'b0001, 4'h8, 4,  1};
      vecs[3]  = '{32'h8000_0001, 1'b1, 3'd1, 32'h5555_5555, 32'h0,         0,   1'b0, 2'b01, 4'b0000, 4'h0, 2,  0};
      vecs[4]  = '{32'h9000_0000, 1'b0, 3'd2, 32'h0,         32'h0,         0,   1'b0, 2'b01, 4'b0000, 4'h0, 2,  0};
      vecs[5]  = '{32'h8000_2008, 1'b0, 3'd2, 32'h0,         32'hCAFE_0000, 0,   1'b1, 2'b01, 4'b0100, 4'h0, 4,  1};
      vecs[6]  = '{32'h8000_0000, 1'b0, 3'd2, 32'h0,         32'h0,         255, 1'b0, 2'b01, 4'b0001, 4'h0, 19, 16};
      vecs[7]  = '{32'h8000_2002, 1'b1, 3'd1, 32'hBEEF_0000, 32'h0,         0,   1'b0, 2'b00, 4'b0100, 4'hC, 4,  1};
      vecs[8]  = '{32'h8000_0000, 1'b0, 3'd3, 32'h0,         32'h0,         0,   1'b0, 2'b01, 4'b0000, 4'h0, 2,  0};
      vecs[9]  = '{32'h7FFF_FFFC, 1'b0, 3'd2, 32'h0,         32'h0,         0,   1'b0, 2'b01, 4'b0000, 4'h0, 2,  0};
      vecs[10] = '{32'h8000_3FFC, 1'b0, 3'd2, 32'h0,         32'h0F0E_0D0C, 1,   1'b0, 2'b00, 4'b1000, 4'h0, 4,  2};
      vecs[11] = '{32'h8000_4000, 1'b0, 3'd2, 32'h0,         32'h0,         0,   1'b0, 2'b01, 4'b0000, 4'h0, 2,  0};

      hresetn  = 1'b0;
      haddr    = '0;
      htrans   = 2'b00;
      hwrite   = 1'b0;
      hsize    = 3'd0;
      hwdata   = '0;
      hreadyin = 1'b1;
      prdata   = '0;
      pready   = 1'b0;
      pslverr  = 1'b0;
      #22;
      reset_checks("por");
      hresetn = 1'b1;

      // BUSY transfer gets a zero-wait OKAY and no APB activity.
      @(posedge hclk); #1;
      haddr  = 32'h8000_0000;
      htrans = 2'b01;
      @(posedge hclk); #1;
      htrans = 2'b00;
      @(negedge hclk);
      check("busy hreadyout", 64'(hreadyout), 64'd1);
      check("busy hresp",     64'(hresp),     64'd0);
      check("busy psel",      64'(psel),      64'd0);

      for (int i = 0; i < 12; i++) begin
         run_vec(vecs[i]);
         check($sformatf("v%0d latency", i),   64'(o_lat),       64'(vecs[i].lat));
         check($sformatf("v%0d hresp", i),     64'(o_resp),      64'(vecs[i].resp));
         check($sformatf("v%0d hresp_pre", i), 64'(o_prev_resp), 64'(vecs[i].resp));
         check($sformatf("v%0d psel", i),      64'(o_psel),      64'(vecs[i].psel));
         check($sformatf("v%0d pstrb", i),     64'(o_pstrb),     64'(vecs[i].pstrb));
         check($sformatf("v%0d access", i),    64'(o_acc),       64'(vecs[i].acc));
         if (vecs[i].psel != 4'b0000)
            check($sformatf("v%0d paddr", i), 64'(o_paddr), 64'(vecs[i].addr));
         if (vecs[i].wr && vecs[i].psel != 4'b0000)
            check($sformatf("v%0d pwdata", i), 64'(o_pwdata), 64'(vecs[i].wdata));
         if (!vecs[i].wr && vecs[i].resp == 2'b00)
            check($sformatf("v%0d hrdata", i), 64'(o_hrdata), 64'(vecs[i].rdata));
      end

      // Back-to-back reads: second address accepted in DONE.
      @(posedge hclk); #1;
      haddr   = 32'h8000_0000;
      htrans  = 2'b10;
      hwrite  = 1'b0;
      hsize   = 3'd2;
      pready  = 1'b1;
      pslverr = 1'b0;
      prdata  = 32'h1111_0000;
      @(posedge hclk); #1;
      htrans = 2'b00;
      @(negedge hclk);
      check("b2b setup0 psel", 64'(psel), 64'h1);
      @(negedge hclk);
      check("b2b access0 psel", 64'(psel), 64'h1);
      check("b2b access0 penable", 64'(penable), 64'd1);
      @(posedge hclk); #1;
      haddr  = 32'h8000_2000;
      htrans = 2'b10;
      @(negedge hclk);
      check("b2b done psel", 64'(psel), 64'h0);
      check("b2b done hreadyout", 64'(hreadyout), 64'd1);
      check("b2b done hrdata", 64'(hrdata), 64'h1111_0000);
      prdata = 32'h2222_0000;
      @(posedge hclk); #1;
      htrans = 2'b00;
      @(negedge hclk);
      check("b2b setup2 psel", 64'(psel), 64'h4);
      check("b2b setup2 paddr", 64'(paddr), 64'h8000_2000);
      @(negedge hclk);
      check("b2b access2 psel", 64'(psel), 64'h4);
      @(negedge hclk);
      check("b2b done2 hreadyout", 64'(hreadyout), 64'd1);
      check("b2b done2 hrdata", 64'(hrdata), 64'h2222_0000);
      check("b2b done2 psel", 64'(psel), 64'h0);

      // Reset asserted in the middle of an ACCESS that the slave stalls.
      @(posedge hclk); #1;
      haddr  = 32'h8000_1000;
      htrans = 2'b10;
      pready = 1'b0;
      @(posedge hclk); #1;
      htrans = 2'b00;
      n_wait = 0;
      while (!penable && n_wait < 10) begin
         @(negedge hclk);
         n_wait++;
      end
      check("rst reached access", 64'(penable), 64'd1);
      @(negedge hclk); #2;
      hresetn = 1'b0;
      #1;
      reset_checks("midrst");
      @(posedge hclk); #2;
      hresetn = 1'b1;
      @(negedge hclk);
      @(negedge hclk);
      check("post rst psel", 64'(psel), 64'h0);
      check("post rst hreadyout", 64'(hreadyout), 64'd1);
      check("post rst penable", 64'(penable), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ahb2apb_bridge_mslv.md
Name: ahb2apb_bridge_mslv

Overview:
Parametrised AHB-Lite slave to APB4 master bridge serving NUM_SLAVES APB peripherals from one contiguous address window. It adds the following:
- Configurable address and data widths.
- Multi-slave decode.
- pstrb generation.
- Two-cycle ERROR responses for decode, alignment, pslverr and pready-timeout faults.

It sits between the AHB fabric (driven by the existing AHB agent) and the APB peripheral cluster.

Parameters:
- ADDR_W, 32, address width of haddr and paddr.
- DATA_W, 32, data width; must be 32 or 64.
- NUM_SLAVES, 4, number of psel lines (1..16).
- BASE_ADDR, 32'h8000_0000, start of the bridge window.
- REGION_BYTES, 32'h1000, bytes per slave region; must be a power of two.
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- hclk in 1: bridge clock.
- hresetn in 1: reset. One clock; reset is asynchronous and active-low.
- haddr in ADDR_W: AHB address.
- htrans in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite in 1: 1 = write.
- hsize in 3: transfer size, log2 of bytes.
- hwdata in DATA_W: write data, valid in the data phase.
- hreadyin in 1: previous transfer complete on the bus.
- hreadyout out 1: bridge ready.
- hresp out 2: 00 OKAY, 01 ERROR.
- hrdata out DATA_W: read data.
- paddr out ADDR_W: APB address.
- pwdata out DATA_W: APB write data.
- pwrite out 1: APB direction.
- pstrb out DATA_W/8: byte strobes.
- psel out NUM_SLAVES: one-hot slave select.
- penable out 1: APB access phase.
- prdata in DATA_W: muxed read data from the selected slave.
- pready in 1: APB ready.
- pslverr in 1: APB error.

Behaviour:
- Reset values: hreadyout=1, hresp=00, hrdata=0, paddr=0, pwdata=0, pwrite=0, pstrb=0, psel=0, penable=0, state=IDLE, timeout counter=0.
- Reset asserted mid-transfer aborts immediately. No further APB or AHB activity until a new valid transfer.
- Valid transfer: hreadyin=1, htrans[1]=1, sampled only while hreadyout=1 (states IDLE, DONE, ERR2). BUSY and IDLE transfers get a zero-wait OKAY.
- Decode fault: haddr outside [BASE_ADDR, BASE_ADDR + NUM_SLAVES*REGION_BYTES).
- Alignment fault: haddr not aligned to 2^hsize, or 2^hsize > DATA_W/8.
- Either fault goes to ERR1 with no APB activity.
- Slave index = (haddr - BASE_ADDR) / REGION_BYTES. paddr = full haddr.
- pstrb: writes set 2^hsize ones shifted by haddr[log2(DATA_W/8)-1:0]; reads set all zero.
- States:
  - IDLE: hreadyout=1. Valid write goes to WDATA; valid read goes to SETUP; fault goes to ERR1.
  - WDATA: hreadyout=0; capture hwdata into pwdata at the clock edge; next state SETUP.
  - SETUP: psel[idx]=1, penable=0; next state ACCESS.
  - ACCESS: psel and penable high; timeout counter increments each cycle.
    - pready=1 and pslverr=0: capture prdata into hrdata (reads only), go to DONE.
    - pready=1 and pslverr=1: go to ERR1.
    - Counter reaches TIMEOUT with pready still 0: drop psel and penable, go to ERR1.
  - DONE: hreadyout=1, hresp=00, psel=0. Accepts the next transfer like IDLE, otherwise returns to IDLE.
  - ERR1: hreadyout=0, hresp=01, psel=0; next state ERR2.
  - ERR2: hreadyout=1, hresp=01. Accepts the next transfer like IDLE.
- Latency with a zero-wait APB slave:
  - Read: address phase at T; hreadyout low at T+1 and T+2; high at T+3 with hrdata valid.
  - Write: hreadyout low at T+1..T+3; high at T+4.
  - Each pready wait cycle adds one cycle.
- APB outputs (paddr, pwrite, pstrb, pwdata) are held stable from SETUP through the end of ACCESS. hrdata holds its last value outside DONE.
- Back-to-back transfers: a transfer accepted in DONE or ERR2 enters WDATA or SETUP the next cycle. psel deasserts for at least one cycle between accesses.

Decomposition:
- Package ahb_apb_pkg holds:
  - HTRANS_* and HRESP_* constants.
  - The bridge_state_e enum.
  - A function size_to_strb(hsize, addr_lsbs, DATA_W).
- One natural sub-module, ahb_apb_decoder: purely combinational address-to-index decode plus fault detection, parameterised by BASE_ADDR, REGION_BYTES and NUM_SLAVES.

Test Plan:
1. Write 32'hDEAD_BEEF to 32'h8000_1004, hsize=2, pready tied 1 → psel=4'b0010, pstrb=4'hF, pwdata=32'hDEAD_BEEF; hreadyout high 4 cycles after the address phase; hresp=00.
2. Read 32'h8000_3000 with prdata=32'h1234_5678 and pready low for 3 ACCESS cycles → psel=4'b1000; hrdata=32'h1234_5678 at hreadyout=1, 6 cycles after the address phase.
3. Byte write to 32'h8000_0003, hsize=0 → pstrb=4'b1000. Halfword at 32'h8000_0001 → ERR1/ERR2 pattern (hreadyout 0 then 1, hresp=01 both cycles), psel never asserted.
4. Read 32'h9000_0000 (unmapped) → two-cycle ERROR, no psel. Then a read pready with pslverr=1 → hresp=01 for two cycles.
5. pready held 0 with TIMEOUT=16 → penable drops after 16 ACCESS cycles, followed by a two-cycle ERROR. Assert hresetn=0 mid-ACCESS on a later transfer → all outputs return to reset values asynchronously.
6. Back-to-back NONSEQ reads to slaves 0 and 2 → second address accepted in DONE; psel shows 0001, then 0000 for one cycle, then 0100.
